// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared UART types and constants
// Rev 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_sync2.sv
// ============================================================================
// uart_sync2 : two-flop synchronizer for asynchronous single-bit inputs
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_receiver.sv
// ============================================================================
// uart_receiver : 8N1 UART receiver with one-entry valid/ready holding register
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic                      sysclk,
    input  logic                      reset,
    input  logic                      UART_RX,
    input  logic                      rx_ready,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      rx_valid,
    output logic                      frame_err,
    output logic                      overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(UART_DATA_BITS);
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(UART_DATA_BITS - 1);

    logic                      rxs;
    rx_state_t                 state;
    rx_state_t                 state_next;
    logic [CW-1:0]             cnt;
    logic [IW-1:0]             bit_idx;
    logic [UART_DATA_BITS-1:0] shreg;
    logic                      cnt_clear;
    logic                      shift_en;
    logic                      deliver;
    logic                      stop_bad;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk   (sysclk),
        .rst_n (reset),
        .d     (UART_RX),
        .q     (rxs)
    );

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        cnt_clear  = 1'b0;
        shift_en   = 1'b0;
        deliver    = 1'b0;
        stop_bad   = 1'b0;
        case (state)
            IDLE: begin
                if (!rxs) begin
                    state_next = START;
                    cnt_clear  = 1'b1;
                end
            end
            START: begin
                if (cnt == HALF_CNT) begin
                    if (!rxs) begin
                        state_next = DATA;
                        cnt_clear  = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt == LAST_CNT) begin
                    shift_en = 1'b1;
                    if (bit_idx == LAST_BIT) state_next = STOP;
                end
            end
            STOP: begin
                if (cnt == LAST_CNT) begin
                    if (rxs) begin
                        deliver    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        stop_bad   = 1'b1;
                        state_next = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                // Hold off until the line returns high so a break is not read as a start bit
                if (rxs) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (cnt_clear || state == IDLE || cnt == LAST_CNT) cnt <= '0;
            else                                                cnt <= cnt + CW'(1);

            if (cnt_clear) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx        <= bit_idx + IW'(1);
                shreg[bit_idx] <= rxs;
            end
        end
    end

    // Holding register: a same-cycle consume frees the slot for the new byte
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= 1'b0;
            if (deliver) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                end else begin
                    overrun  <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_receiver.sv
// ============================================================================
// tb_uart_receiver : scenario-driven self-checking bench for uart_receiver
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_receiver;

    localparam int CPB = 16;
    localparam int LAT = 3 + CPB / 2 + 9 * CPB;

    logic       sysclk   = 1'b0;
    logic       reset    = 1'b0;
    logic       UART_RX  = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .UART_RX   (UART_RX),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 sysclk = ~sysclk;

    int cyc = 0;
    always @(posedge sysclk) cyc++;

    int   err_pulses = 0;
    int   ovr_pulses = 0;
    int   wide_pulses = 0;
    int   both_pulses = 0;
    int   fall_count = 0;
    int   rise_cycle = -1;
    logic prev_valid = 1'b0;
    logic prev_ferr  = 1'b0;
    logic prev_ovr   = 1'b0;

    always @(negedge sysclk) begin
        if (frame_err) err_pulses++;
        if (overrun) ovr_pulses++;
        if ((frame_err && prev_ferr) || (overrun && prev_ovr)) wide_pulses++;
        if (frame_err && overrun) both_pulses++;
        if (rx_valid && !prev_valid) rise_cycle = cyc;
        if (!rx_valid && prev_valid) fall_count++;
        prev_valid = rx_valid;
        prev_ferr  = frame_err;
        prev_ovr   = overrun;
    end

    logic [7:0] exp_q[$];
    logic [7:0] exp_b;
    int checks = 0;
    int errors = 0;

    task automatic send_bits(input logic v, input int n);
        UART_RX = v;
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        send_bits(1'b0, CPB);
        for (int i = 0; i < 8; i++) send_bits(b[i], CPB);
        send_bits(stop_bit, CPB);
    endtask

    task automatic pulse_ready();
        rx_ready = 1'b1;
        @(posedge sysclk);
        #1;
        rx_ready = 1'b0;
    endtask

    task automatic test_reset();
        send_bits(1'b1, 3);
        checks++;
        if ({rx_data, rx_valid, frame_err, overrun} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 000", {rx_data, rx_valid, frame_err, overrun});
        end
        reset = 1'b1;
        send_bits(1'b1, 5);
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_valid: got %b expected 0", rx_valid);
        end
    endtask

    task automatic test_single_frame();
        int e0, o0, start;
        e0 = err_pulses; o0 = ovr_pulses; rise_cycle = -1;
        start = cyc;
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        checks++;
        if (rise_cycle < start + LAT - 1 || rise_cycle > start + LAT + 1) begin
            errors++;
            $display("FAIL latency: got %0d expected %0d+-1", rise_cycle - start, LAT);
        end
        exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== exp_b) begin
            errors++;
            $display("FAIL single_data: got valid=%b data=%h expected valid=1 data=%h", rx_valid, rx_data, exp_b);
        end
        send_bits(1'b1, 10);
        checks++;
        if (rx_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_hold: got valid=%b expected 1", rx_valid);
        end
        pulse_ready();
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_consume: got valid=%b expected 0", rx_valid);
        end
        checks++;
        if (err_pulses != e0 || ovr_pulses != o0) begin
            errors++;
            $display("FAIL single_flags: got ferr=%0d ovr=%0d expected 0 0", err_pulses - e0, ovr_pulses - o0);
        end
    endtask

    task automatic test_glitch();
        int e0;
        e0 = err_pulses; rise_cycle = -1;
        send_bits(1'b0, 4);
        send_bits(1'b1, 40);
        checks++;
        if (rise_cycle != -1 || err_pulses != e0) begin
            errors++;
            $display("FAIL glitch_reject: got rise=%0d ferr=%0d expected none", rise_cycle, err_pulses - e0);
        end
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== exp_b) begin
            errors++;
            $display("FAIL glitch_next_frame: got valid=%b data=%h expected valid=1 data=%h", rx_valid, rx_data, exp_b);
        end
        pulse_ready();
    endtask

    task automatic test_frame_error();
        int e0;
        e0 = err_pulses; rise_cycle = -1;
        send_frame(8'hA5, 1'b0);
        send_bits(1'b0, 40);
        send_bits(1'b1, 200);
        checks++;
        if (err_pulses != e0 + 1) begin
            errors++;
            $display("FAIL frame_err_count: got %0d expected 1", err_pulses - e0);
        end
        checks++;
        if (rx_valid !== 1'b0 || rise_cycle != -1) begin
            errors++;
            $display("FAIL frame_err_no_data: got valid=%b rise=%0d expected valid=0 rise=-1", rx_valid, rise_cycle);
        end
        exp_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b1);
        exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== exp_b) begin
            errors++;
            $display("FAIL frame_err_recover: got valid=%b data=%h expected valid=1 data=%h", rx_valid, rx_data, exp_b);
        end
        pulse_ready();
    endtask

    task automatic test_back_to_back_overrun();
        int e0, o0;
        e0 = err_pulses; o0 = ovr_pulses;
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        send_bits(1'b1, 5);
        exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== exp_b) begin
            errors++;
            $display("FAIL overrun_data: got valid=%b data=%h expected valid=1 data=%h", rx_valid, rx_data, exp_b);
        end
        checks++;
        if (ovr_pulses != o0 + 1 || err_pulses != e0) begin
            errors++;
            $display("FAIL overrun_count: got ovr=%0d ferr=%0d expected 1 0", ovr_pulses - o0, err_pulses - e0);
        end
        pulse_ready();
        checks++;
        if (rx_valid !== 1'b0 || rx_data !== 8'h12) begin
            errors++;
            $display("FAIL overrun_consume: got valid=%b data=%h expected valid=0 data=12", rx_valid, rx_data);
        end
    endtask

    task automatic test_back_to_back_accept();
        int o0, f0, c2;
        o0 = ovr_pulses;
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        send_frame(8'h12, 1'b1);
        exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== exp_b) begin
            errors++;
            $display("FAIL accept_first: got valid=%b data=%h expected valid=1 data=%h", rx_valid, rx_data, exp_b);
        end
        f0 = fall_count;
        c2 = cyc;
        fork
            send_frame(8'h34, 1'b1);
            begin
                while (cyc < c2 + LAT - 1) begin
                    @(posedge sysclk);
                    #1;
                end
                pulse_ready();
            end
        join
        send_bits(1'b1, 5);
        exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== exp_b) begin
            errors++;
            $display("FAIL accept_second: got valid=%b data=%h expected valid=1 data=%h", rx_valid, rx_data, exp_b);
        end
        checks++;
        if (ovr_pulses != o0 || fall_count != f0) begin
            errors++;
            $display("FAIL accept_no_gap: got ovr=%0d falls=%0d expected 0 0", ovr_pulses - o0, fall_count - f0);
        end
    endtask

    task automatic test_reset_mid_frame();
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (60) @(posedge sysclk);
                #1;
                reset = 1'b0;
                repeat (2) @(posedge sysclk);
                #1;
                checks++;
                if ({rx_data, rx_valid, frame_err, overrun} !== 11'd0) begin
                    errors++;
                    $display("FAIL midframe_reset_outputs: got %h expected 000", {rx_data, rx_valid, frame_err, overrun});
                end
                repeat (3) @(posedge sysclk);
                #1;
                reset = 1'b1;
            end
        join
        exp_q.delete();
        send_bits(1'b1, 40);
        rise_cycle = -1;
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1);
        exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== exp_b || rise_cycle == -1) begin
            errors++;
            $display("FAIL midframe_recover: got valid=%b data=%h expected valid=1 data=%h", rx_valid, rx_data, exp_b);
        end
    endtask

    task automatic test_pulse_shape();
        checks++;
        if (wide_pulses != 0 || both_pulses != 0) begin
            errors++;
            $display("FAIL pulse_shape: got wide=%0d coincident=%0d expected 0 0", wide_pulses, both_pulses);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_glitch();
        test_frame_error();
        test_back_to_back_overrun();
        test_back_to_back_accept();
        test_reset_mid_frame();
        test_pulse_shape();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
